// File: rtl/bcd_result_conv_pkg.sv
// Shared definitions for the binary-to-BCD result converter:
// FSM states, data widths, the conversion limit and the blank-mask helper.
package bcd_result_conv_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned BIN_W      = 14;
  localparam int unsigned BCD_W      = 16;
  localparam logic [13:0] MAX_VALUE  = 14'd9999;
  localparam int unsigned ITERATIONS = 14;

  // Display pattern used after reset and for an out-of-range value: a single "0".
  localparam logic [3:0]  BLANK_ZERO = 4'b1110;

  // Leading-zero blank mask; the units digit is never blanked so zero shows "0".
  function automatic logic [3:0] blank_mask(input logic [15:0] bcd);
    logic b3;
    logic b2;
    logic b1;
    b3 = (bcd[15:12] == 4'd0);
    b2 = b3 & (bcd[11:8] == 4'd0);
    b1 = b2 & (bcd[7:4] == 4'd0);
    return {b3, b2, b1, 1'b0};
  endfunction

endpackage

// File: rtl/bcd_result_conv_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  // Conditional +3 correction of a single digit.
  always_comb begin
    o_digit = i_digit;
    if (i_digit >= 4'd5) begin
      o_digit = i_digit + 4'd3;
    end else begin
      o_digit = i_digit;
    end
  end

endmodule

// File: rtl/bcd_result_conv.sv
// Sequential binary-to-BCD converter (double dabble, one iteration per clock)
// with leading-zero blanking and an out-of-range overflow indication.
module bcd_result_conv
  import bcd_result_conv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] bin_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd_out,
  output logic [3:0]  blank,
  output logic        overflow
);

  localparam logic [3:0] LAST_ITER = 4'(ITERATIONS - 1);

  state_t             r_state;
  logic [BIN_W-1:0]   r_shift;
  logic [BCD_W-1:0]   r_scratch;
  logic [3:0]         r_count;
  logic               r_busy;
  logic               r_done;
  logic [BCD_W-1:0]   r_bcd;
  logic [3:0]         r_blank;
  logic               r_overflow;

  state_t             w_state;
  logic [BIN_W-1:0]   w_shift;
  logic [BCD_W-1:0]   w_scratch;
  logic [3:0]         w_count;
  logic               w_busy;
  logic               w_done;
  logic [BCD_W-1:0]   w_bcd;
  logic [3:0]         w_blank;
  logic               w_overflow;

  logic [BCD_W-1:0]         w_adj;
  logic [BCD_W+BIN_W-1:0]   w_cat;

  // One add-3 corrector per decimal digit of the scratch register.
  for (genvar g = 0; g < 4; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_digit (r_scratch[4*g+3:4*g]),
      .o_digit (w_adj[4*g+3:4*g])
    );
  end

  // One double-dabble step: corrected scratch and binary shifted left as one word.
  assign w_cat = {w_adj, r_shift} << 1;

  // Next-state and next-register logic for the IDLE/SHIFT controller.
  always_comb begin
    w_state    = r_state;
    w_shift    = r_shift;
    w_scratch  = r_scratch;
    w_count    = r_count;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_bcd      = r_bcd;
    w_blank    = r_blank;
    w_overflow = r_overflow;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (start) begin
          if (bin_in > MAX_VALUE) begin
            // Out of range: report immediately, no conversion is started.
            w_overflow = 1'b1;
            w_bcd      = 16'h0000;
            w_blank    = BLANK_ZERO;
            w_done     = 1'b1;
          end else begin
            w_shift   = bin_in;
            w_scratch = 16'h0000;
            w_count   = 4'd0;
            w_busy    = 1'b1;
            w_state   = SHIFT;
          end
        end else begin
          w_state = IDLE;
        end
      end
      SHIFT: begin
        w_shift   = w_cat[BIN_W-1:0];
        w_scratch = w_cat[BCD_W+BIN_W-1:BIN_W];
        w_count   = r_count + 4'd1;
        if (r_count == LAST_ITER) begin
          // Final iteration: publish the result and return to IDLE.
          w_bcd      = w_cat[BCD_W+BIN_W-1:BIN_W];
          w_blank    = blank_mask(w_cat[BCD_W+BIN_W-1:BIN_W]);
          w_overflow = 1'b0;
          w_done     = 1'b1;
          w_busy     = 1'b0;
          w_count    = 4'd0;
          w_state    = IDLE;
        end else begin
          w_state = SHIFT;
        end
      end
      default: begin
        w_state = IDLE;
        w_busy  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_shift    <= 14'd0;
      r_scratch  <= 16'h0000;
      r_count    <= 4'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= 16'h0000;
      r_blank    <= BLANK_ZERO;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_shift    <= w_shift;
      r_scratch  <= w_scratch;
      r_count    <= w_count;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_bcd      <= w_bcd;
      r_blank    <= w_blank;
      r_overflow <= w_overflow;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign bcd_out  = r_bcd;
  assign blank    = r_blank;
  assign overflow = r_overflow;

endmodule

// File: doc/bcd_result_conv.md
BCD_RESULT_CONV -- requirements
Module: bcd_result_conv

Interface
REQ-001 The block SHALL use one clock and one reset: reset is asynchronous and active-low.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous reset, active-low (asserted at 0).
REQ-004 start  input  1  conversion request; sampled only in IDLE.
REQ-005 bin_in  input  14  unsigned binary result to convert; sampled on the accepting edge.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  one-cycle pulse when bcd_out, blank and overflow are updated.
REQ-008 bcd_out  output  16  four packed BCD digits, [15:12] thousands down to [3:0] units.
REQ-009 blank  output  4  per-digit leading-zero blank mask, bit i pairs with bcd_out[4i+3:4i].
REQ-010 overflow  output  1  last accepted value exceeded 9999.

Function
REQ-011 States SHALL be IDLE and SHIFT; reset state IDLE.
REQ-012 IDLE, start=1, bin_in<=9999: the block SHALL load bin_in into a 14-bit shift register, clear a 16-bit BCD scratch register, clear the iteration count, go to SHIFT and set busy.
REQ-013 IDLE, start=1, bin_in>9999: the block SHALL stay in IDLE, set overflow=1, set bcd_out=16'h0000 and blank=4'b1110, and pulse done on the next cycle (1-cycle latency).
REQ-014 Each SHIFT cycle SHALL perform one double-dabble iteration: add 3 to every scratch digit >=5, then shift {scratch, shift register} left by one.
REQ-015 Exactly 14 iterations SHALL occur; the edge performing iteration 14 SHALL write the final scratch value to bcd_out, clear overflow, update blank, pulse done, clear busy and return to IDLE.
REQ-016 Latency: start accepted at edge N -> done high during the cycle after edge N+14; busy high during the cycles after edges N through N+13.
REQ-017 start while busy=1 SHALL be ignored, with no queueing and no effect on the running conversion.
REQ-018 start during the done-pulse cycle SHALL be accepted (the block is already in IDLE).
REQ-019 bcd_out, blank and overflow SHALL hold their values between done pulses; a new start SHALL NOT clear them before completion.
REQ-020 blank[3]=(d3==0); blank[2]=blank[3]&(d2==0); blank[1]=blank[2]&(d1==0); blank[0]=0 always, so value 0 shows a single "0".
REQ-021 Digits SHALL never exceed 9 for any input from 0 to 9999; bin_in changes while busy SHALL have no effect.

Reset
REQ-022 While rst=0 the block SHALL be in state IDLE with busy=0, done=0, overflow=0, bcd_out=16'h0000, blank=4'b1110, and shift, scratch and count registers at 0.
REQ-023 Reset asserted mid-conversion SHALL abort immediately, with no done pulse; after release the block SHALL accept a new start on the first edge.

Structure
REQ-024 A shared package SHALL hold the state enum (IDLE, SHIFT), BIN_W=14, BCD_W=16, MAX_VALUE=9999 and ITERATIONS=14.
REQ-025 A combinational sub-module bcd_add3 (4-bit in, 4-bit out, +3 when >=5) SHALL be instantiated four times, once per digit.

Verification
REQ-026 Input 0 -> done 14 cycles after acceptance, bcd_out=16'h0000, blank=4'b1110, overflow=0.
REQ-027 Input 9999 -> bcd_out=16'h9999, blank=4'b0000; input 42 -> bcd_out=16'h0042, blank=4'b1100.
REQ-028 Input 10000, then input 16383 -> each gives done after 1 cycle, overflow=1, bcd_out=16'h0000.
REQ-029 Input 1234, then start with bin_in=5678 at cycle 5 of the conversion -> result 16'h1234, with only one done pulse.
REQ-030 Input 1234, rst=0 at cycle 7, release, then input 305 -> no done pulse for 1234, then bcd_out=16'h0305, blank=4'b1000.
REQ-031 Back-to-back: start held high continuously with 1 then 2 -> done pulses spaced 15 cycles apart, results 16'h0001 then 16'h0002.
